// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite master bridging a valid/ready command/response port to AXI-Lite.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axil_master #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          STRB_WIDTH     = DATA_WIDTH / 8,
  parameter logic [2:0]  PROT           = 3'b000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] wstrb_reg;
  logic                  aw_done_reg, w_done_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            resp_reg;
  logic                  accept, aw_hs, w_hs, timeout_hit;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] count_reg;
  logic             busy;

  assign busy = (state_reg != IDLE) && (state_reg != DONE);
  // Fires on the last counted cycle so the abandon edge lands TIMEOUT_CYCLES after acceptance.
  assign timeout_hit = busy && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else if (accept)
      count_reg <= '0;
    else if (busy)
      count_reg <= count_reg + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready      = (state_reg == IDLE);
  assign accept         = cmd_valid && cmd_ready;
  assign rsp_valid      = (state_reg == DONE);
  assign rsp_rdata      = rdata_reg;
  assign rsp_resp       = resp_reg;

  // Abandoning a timed-out transaction drops every handshake signal in the same cycle.
  assign m_axil_awvalid = (state_reg == WR_ADDR_DATA) && !aw_done_reg && !timeout_hit;
  assign m_axil_wvalid  = (state_reg == WR_ADDR_DATA) && !w_done_reg && !timeout_hit;
  assign m_axil_bready  = (state_reg == WR_RESP) && !timeout_hit;
  assign m_axil_arvalid = (state_reg == RD_ADDR) && !timeout_hit;
  assign m_axil_rready  = (state_reg == RD_DATA) && !timeout_hit;

  assign m_axil_awaddr  = addr_reg;
  assign m_axil_araddr  = addr_reg;
  assign m_axil_wdata   = wdata_reg;
  assign m_axil_wstrb   = wstrb_reg;
  assign m_axil_awprot  = PROT;
  assign m_axil_arprot  = PROT;

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid && m_axil_wready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:         if (cmd_valid) state_next = cmd_we ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (timeout_hit) state_next = DONE;
                    else if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = WR_RESP;
      WR_RESP:      if (timeout_hit) state_next = DONE;
                    else if (m_axil_bvalid) state_next = DONE;
      RD_ADDR:      if (timeout_hit) state_next = DONE;
                    else if (m_axil_arready) state_next = RD_DATA;
      RD_DATA:      if (timeout_hit) state_next = DONE;
                    else if (m_axil_rvalid) state_next = DONE;
      DONE:         if (rsp_ready) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      rdata_reg   <= '0;
      resp_reg    <= 2'b00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg    <= cmd_addr;
        wdata_reg   <= cmd_wdata;
        wstrb_reg   <= cmd_wstrb;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
      if (timeout_hit) begin
        rdata_reg <= '0;
        resp_reg  <= 2'b10;
      end else if (state_reg == WR_RESP && m_axil_bvalid) begin
        rdata_reg <= '0;
        resp_reg  <= m_axil_bresp;
      end else if (state_reg == RD_DATA && m_axil_rvalid) begin
        rdata_reg <= m_axil_rdata;
        resp_reg  <= m_axil_rresp;
      end
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// Directed self-checking bench for axil_master; the watchdog case runs when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata = 0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic        arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0]  bresp = 0, rresp = 0;

  int vec_count = 0;
  int err_count = 0;

  axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
    .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
    .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
    .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 0;
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
    check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #12 rst = 0;
    #3; tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'd0);
    check("rst_rsp", {rsp_rdata, rsp_resp}, 64'd0);
    check("rst_addr", {awaddr, araddr}, 64'd0);
    check("prot", {awprot, arprot}, 64'd0);

    // Zero-wait write
    awready = 1; wready = 1;
    issue(1, 32'h08, 32'h0000_00FF, 4'hF);
    check("w0_cmd_ready", 64'(cmd_ready), 64'd0);
    check("w0_valids", {awvalid, wvalid, bready}, 64'b110);
    check("w0_payload", {awaddr, wdata}, {32'h08, 32'hFF});
    check("w0_wstrb", 64'(wstrb), 64'hF);
    tick();
    check("w0_beats_once", {awvalid, wvalid, bready, rsp_valid}, 64'b0010);
    bvalid = 1; bresp = 2'b00;
    tick();
    bvalid = 0;
    check("w0_rsp_n3", {rsp_valid, bready}, 64'b10);
    check("w0_rsp", {rsp_rdata, rsp_resp}, 64'd0);
    consume("w0");

    // Zero-wait read, OKAY
    arready = 1;
    issue(0, 32'h00, 32'h0, 4'h0);
    check("r0_ar", {arvalid, rready, cmd_ready}, 64'b100);
    check("r0_araddr", 64'(araddr), 64'h0);
    tick();
    check("r0_ar_once", {arvalid, rready}, 64'b01);
    rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    tick();
    rvalid = 0;
    check("r0_rsp", {rsp_valid, rready, rsp_rdata, rsp_resp}, {2'b10, 32'hDEAD_BEEF, 2'b00});
    consume("r0");

    // Write with immediate wready, awready two cycles late, DECERR forwarded
    awready = 0; wready = 1;
    issue(1, 32'h40, 32'hA5A5_0001, 4'h3);
    check("w1_c1", {awvalid, wvalid, bready}, 64'b110);
    tick();
    check("w1_c2", {awvalid, wvalid, bready}, 64'b100);
    check("w1_aw_stable", {awaddr, 28'h0, wstrb}, {32'h40, 32'h3});
    tick();
    check("w1_c3", {awvalid, wvalid, bready}, 64'b100);
    awready = 1;
    tick();
    check("w1_bready", {awvalid, wvalid, bready}, 64'b001);
    bvalid = 1; bresp = 2'b11;
    tick();
    bvalid = 0;
    check("w1_rsp", {rsp_valid, bready, rsp_rdata, rsp_resp}, {2'b10, 32'h0, 2'b11});
    consume("w1");

    // Stray B beat in IDLE is not consumed
    bvalid = 1;
    tick();
    check("stray_b", 64'(bready), 64'd0);
    bvalid = 0;

    // Read with SLVERR, response stalled five cycles
    issue(0, 32'h1C, 32'h0, 4'h0);
    tick();
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    tick();
    rvalid = 0; rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("r1_hold%0d", i), {rsp_valid, cmd_ready, rsp_rdata, rsp_resp},
            {2'b10, 32'h1234_5678, 2'b10});
      tick();
    end
    cmd_valid = 1; cmd_we = 0; arready = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("r1_no_overlap", {rsp_valid, cmd_ready, arvalid}, 64'b010);

    // Command now accepted; reset mid-read while arvalid is high
    tick();
    cmd_valid = 0;
    check("r2_arvalid", {arvalid, cmd_ready}, 64'b10);
    #2 rst = 1;
    #1;
    check("async_rst", {arvalid, rready, rsp_valid, cmd_ready}, 64'b0001);
    #3 rst = 0;
    tick();
    check("post_rst", {cmd_ready, arvalid, rsp_valid}, 64'b100);

`ifdef AXIL_MASTER_TIMEOUT_EN
    begin
      int k;
      awready = 1; wready = 1; bvalid = 0;
      issue(1, 32'h10, 32'h55, 4'hF);
      k = 1;
      while (!rsp_valid && k < 40) begin
        tick();
        k++;
      end
      check("to_seen", 64'(rsp_valid), 64'd1);
      check("to_latency_window", 64'(k >= 15 && k <= 17), 64'd1);
      check("to_rsp", {rsp_rdata, rsp_resp}, {32'h0, 2'b10});
      bvalid = 1; bresp = 2'b00;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("to_late_b%0d", i), {bready, rsp_resp}, {1'b0, 2'b10});
        tick();
      end
      consume("to");
      check("to_idle_bready", 64'(bready), 64'd0);
      bvalid = 0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
